// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Y86 memory-access stage. Takes the ex_mem register outputs
//                (mem_*), performs at most one data-memory read or write over
//                a req/ack handshake, and drives the mem_wb pipeline registers
//                (wb_*). Upstream is held while an access is outstanding. A
//                halt, illegal instruction or address fault freezes the
//                machine until reset.
//  Ports       : clk, rst (async, active-low)
//                mem_*      : instruction fields from ex_mem
//                mem_stall  : combinational hold request to upstream stages
//                dmem_*     : data-memory request/response handshake
//                wb_*       : registered results toward write-back
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT = 255  // ACCESS cycles without ack before ADR fault (1..255)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_icode,
  input  logic [7:0]  mem_rA,
  input  logic [7:0]  mem_rB,
  input  logic [31:0] mem_valA,
  input  logic [31:0] mem_valP,
  input  logic [31:0] mem_valE,
  input  logic [7:0]  mem_dstE,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  output logic [7:0]  wb_icode,
  output logic [31:0] wb_valE,
  output logic [31:0] wb_valM,
  output logic [7:0]  wb_dstE,
  output logic [7:0]  wb_dstM,
  output logic [2:0]  wb_stat
);

  localparam logic [7:0] c_i_halt   = 8'h0;
  localparam logic [7:0] c_i_nop    = 8'h1;
  localparam logic [7:0] c_i_rmmovl = 8'h4;
  localparam logic [7:0] c_i_mrmovl = 8'h5;
  localparam logic [7:0] c_i_call   = 8'h8;
  localparam logic [7:0] c_i_ret    = 8'h9;
  localparam logic [7:0] c_i_pushl  = 8'hA;
  localparam logic [7:0] c_i_popl   = 8'hB;
  localparam logic [7:0] c_r_none   = 8'hF;

  localparam logic [2:0] c_s_aok = 3'd1;
  localparam logic [2:0] c_s_hlt = 3'd2;
  localparam logic [2:0] c_s_adr = 3'd3;
  localparam logic [2:0] c_s_ins = 3'd4;

  localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);
  localparam logic [7:0] c_to_max  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wb_icode_q, wb_icode_d;
  logic [31:0] wb_vale_q, wb_vale_d;
  logic [31:0] wb_valm_q, wb_valm_d;
  logic [7:0]  wb_dste_q, wb_dste_d;
  logic [7:0]  wb_dstm_q, wb_dstm_d;
  logic [2:0]  wb_stat_q, wb_stat_d;

  logic        w_is_read;
  logic        w_is_write;
  logic        w_is_mem;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_loads_dstm;

  // rB only travels alongside the instruction for tracing.
  logic unused_rb;
  assign unused_rb = ^mem_rB;

  assign w_is_read    = (mem_icode == c_i_mrmovl) || (mem_icode == c_i_popl) ||
                        (mem_icode == c_i_ret);
  assign w_is_write   = (mem_icode == c_i_rmmovl) || (mem_icode == c_i_pushl) ||
                        (mem_icode == c_i_call);
  assign w_is_mem     = w_is_read || w_is_write;
  assign w_addr       = ((mem_icode == c_i_popl) || (mem_icode == c_i_ret)) ? mem_valA : mem_valE;
  assign w_wdata      = (mem_icode == c_i_call) ? mem_valP : mem_valA;
  assign w_loads_dstm = (mem_icode == c_i_mrmovl) || (mem_icode == c_i_popl);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    // wb_* fall back to a bubble unless an instruction completes this cycle.
    wb_icode_d = c_i_nop;
    wb_vale_d  = 32'h0;
    wb_valm_d  = 32'h0;
    wb_dste_d  = c_r_none;
    wb_dstm_d  = c_r_none;
    wb_stat_d  = c_s_aok;
    mem_stall  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_is_mem) begin
          if (w_addr[1:0] != 2'b00) begin
            // Misaligned: fault without touching memory, and no register writes.
            wb_icode_d = mem_icode;
            wb_vale_d  = mem_valE;
            wb_stat_d  = c_s_adr;
            state_d    = ST_HALTED;
          end else begin
            mem_stall = 1'b1;
            req_d     = 1'b1;
            we_d      = w_is_write;
            addr_d    = w_addr;
            wdata_d   = w_wdata;
            cnt_d     = 8'h0;
            state_d   = ST_ACCESS;
          end
        end else begin
          wb_icode_d = mem_icode;
          wb_vale_d  = mem_valE;
          wb_dste_d  = mem_dstE;
          if (mem_icode == c_i_halt) begin
            wb_stat_d = c_s_hlt;
            state_d   = ST_HALTED;
          end else if (mem_icode > c_i_popl) begin
            wb_stat_d = c_s_ins;
            state_d   = ST_HALTED;
          end
        end
      end

      ST_ACCESS: begin
        // Upstream is held during ACCESS, so mem_* still describe this access.
        mem_stall = !dmem_ack;
        if (dmem_ack) begin
          req_d      = 1'b0;
          wb_icode_d = mem_icode;
          wb_vale_d  = mem_valE;
          if (dmem_err) begin
            wb_stat_d = c_s_adr;
            state_d   = ST_HALTED;
          end else begin
            wb_valm_d = we_q ? 32'h0 : dmem_rdata;
            wb_dste_d = mem_dstE;
            wb_dstm_d = w_loads_dstm ? mem_rA : c_r_none;
            state_d   = ST_IDLE;
          end
        end else if (cnt_q == c_to_last) begin
          // Checked after ack so a late ack in the expiry cycle still completes.
          req_d      = 1'b0;
          wb_icode_d = mem_icode;
          wb_vale_d  = mem_valE;
          wb_stat_d  = c_s_adr;
          state_d    = ST_HALTED;
        end else if (cnt_q != c_to_max) begin
          cnt_d = cnt_q + 8'h1;
        end
      end

      ST_HALTED: begin
        mem_stall = 1'b1;
        req_d     = 1'b0;
      end

      default: begin
        mem_stall = 1'b1;
        req_d     = 1'b0;
        state_d   = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'h0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wb_icode_q <= c_i_nop;
      wb_vale_q  <= 32'h0;
      wb_valm_q  <= 32'h0;
      wb_dste_q  <= c_r_none;
      wb_dstm_q  <= c_r_none;
      wb_stat_q  <= c_s_aok;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_icode_q <= wb_icode_d;
      wb_vale_q  <= wb_vale_d;
      wb_valm_q  <= wb_valm_d;
      wb_dste_q  <= wb_dste_d;
      wb_dstm_q  <= wb_dstm_d;
      wb_stat_q  <= wb_stat_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wb_icode   = wb_icode_q;
  assign wb_valE    = wb_vale_q;
  assign wb_valM    = wb_valm_q;
  assign wb_dstE    = wb_dste_q;
  assign wb_dstM    = wb_dstm_q;
  assign wb_stat    = wb_stat_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Scoreboard bench for mem_stage. Stimulus pushes expected
//                write-back records and memory requests into queues; a
//                monitor pops and compares whenever a non-bubble wb record
//                or a new dmem request appears.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  mem_icode, mem_rA, mem_rB, mem_dstE;
  logic [31:0] mem_valA, mem_valP, mem_valE;
  logic        mem_stall;
  logic        dmem_req, dmem_we, dmem_ack, dmem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  wb_icode, wb_dstE, wb_dstM;
  logic [31:0] wb_valE, wb_valM;
  logic [2:0]  wb_stat;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_icode(mem_icode), .mem_rA(mem_rA), .mem_rB(mem_rB),
    .mem_valA(mem_valA), .mem_valP(mem_valP), .mem_valE(mem_valE), .mem_dstE(mem_dstE),
    .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
    .wb_icode(wb_icode), .wb_valE(wb_valE), .wb_valM(wb_valM),
    .wb_dstE(wb_dstE), .wb_dstM(wb_dstM), .wb_stat(wb_stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  icode;
    logic [31:0] val_e;
    logic [31:0] val_m;
    logic [7:0]  dst_e;
    logic [7:0]  dst_m;
    logic [2:0]  stat;
    bit          full;   // 0: only icode and stat are defined for this record
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_exp_t;

  wb_exp_t  wb_sb[$];
  req_exp_t req_sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wb(input logic [7:0] ic, input logic [31:0] ve, input logic [31:0] vm,
                         input logic [7:0] de, input logic [7:0] dm, input logic [2:0] st,
                         input bit full);
    wb_exp_t e;
    e.icode = ic; e.val_e = ve; e.val_m = vm; e.dst_e = de; e.dst_m = dm; e.stat = st; e.full = full;
    wb_sb.push_back(e);
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_exp_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    req_sb.push_back(r);
  endtask

  // ---------------------------------------------------------------- monitor
  logic     mon_req_prev = 1'b0;
  bit       mon_req_valid = 1'b0;
  req_exp_t mon_req;
  wb_exp_t  mon_wb;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_req_prev  = 1'b0;
        mon_req_valid = 1'b0;
      end else begin
        if (!(wb_icode == 8'h1 && wb_stat == 3'd1)) begin
          if (wb_sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL wb_unexpected: actual icode=%h stat=%0d required=no record", wb_icode, wb_stat);
          end else begin
            mon_wb = wb_sb.pop_front();
            chk("wb_icode", 32'(wb_icode), 32'(mon_wb.icode));
            chk("wb_stat",  32'(wb_stat),  32'(mon_wb.stat));
            if (mon_wb.full) begin
              chk("wb_valE", wb_valE, mon_wb.val_e);
              chk("wb_valM", wb_valM, mon_wb.val_m);
              chk("wb_dstE", 32'(wb_dstE), 32'(mon_wb.dst_e));
              chk("wb_dstM", 32'(wb_dstM), 32'(mon_wb.dst_m));
            end
          end
        end
        if (dmem_req && !mon_req_prev) begin
          if (req_sb.size() == 0) begin
            checks++; failures++;
            mon_req_valid = 1'b0;
            $display("FAIL req_unexpected: actual addr=%h we=%0d required=no request", dmem_addr, dmem_we);
          end else begin
            mon_req = req_sb.pop_front();
            mon_req_valid = 1'b1;
            chk("req_we",   32'(dmem_we), 32'(mon_req.we));
            chk("req_addr", dmem_addr, mon_req.addr);
            if (mon_req.we) chk("req_wdata", dmem_wdata, mon_req.wdata);
          end
        end else if (dmem_req && mon_req_valid) begin
          chk("req_addr_stable", dmem_addr, mon_req.addr);
          chk("req_we_stable",   32'(dmem_we), 32'(mon_req.we));
        end
        mon_req_prev = dmem_req;
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic drive(input logic [7:0] ic, input logic [7:0] ra, input logic [31:0] va,
                       input logic [31:0] vp, input logic [31:0] ve, input logic [7:0] de);
    mem_icode = ic; mem_rA = ra; mem_rB = 8'hF;
    mem_valA = va; mem_valP = vp; mem_valE = ve; mem_dstE = de;
  endtask

  task automatic nop();
    drive(8'h1, 8'hF, 32'h0, 32'h0, 32'h0, 8'hF);
  endtask

  // Presents one instruction (starting just after a posedge) and runs max_cyc
  // cycles. ack is pulsed ack_after cycles after the request first appears
  // (never if negative). Reports stall cycles, request cycle and wb cycle.
  task automatic run_instr(input logic [7:0] ic, input logic [7:0] ra, input logic [31:0] va,
                           input logic [31:0] vp, input logic [31:0] ve, input logic [7:0] de,
                           input int ack_after, input logic [31:0] rd, input logic er,
                           input int max_cyc, output int stalls, output int req_c, output int wb_c);
    logic s;
    bit   accepted;
    stalls = 0; req_c = -1; wb_c = -1; accepted = 0;
    drive(ic, ra, va, vp, ve, de);
    for (int c = 0; c < max_cyc; c++) begin
      if (dmem_req && req_c < 0) req_c = c;
      dmem_ack   = (req_c >= 0 && ack_after >= 0 && (c - req_c) == ack_after);
      dmem_rdata = rd;
      dmem_err   = er;
      @(negedge clk);
      s = mem_stall;
      if (wb_c < 0 && !(wb_icode == 8'h1 && wb_stat == 3'd1)) wb_c = c;
      if (s && !accepted) stalls++;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      dmem_err = 1'b0;
      if (!s && !accepted) begin
        accepted = 1;
        nop();
      end
    end
    nop();
  endtask

  task automatic do_reset();
    nop();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic chk_frozen(input string tag);
    @(negedge clk);
    chk({tag, "_stall"}, 32'(mem_stall), 32'h1);
    chk({tag, "_req"},   32'(dmem_req),  32'h0);
    chk({tag, "_bubble_icode"}, 32'(wb_icode), 32'h1);
    chk({tag, "_bubble_stat"},  32'(wb_stat),  32'h1);
    @(posedge clk); #1;
  endtask

  int st, rc, wc;

  initial begin : stimulus
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = 32'h0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk("rst_req",   32'(dmem_req), 32'h0);
    chk("rst_we",    32'(dmem_we),  32'h0);
    chk("rst_addr",  dmem_addr,     32'h0);
    chk("rst_wdata", dmem_wdata,    32'h0);
    chk("rst_wb_icode", 32'(wb_icode), 32'h1);
    chk("rst_wb_valE",  wb_valE,       32'h0);
    chk("rst_wb_valM",  wb_valM,       32'h0);
    chk("rst_wb_dstE",  32'(wb_dstE),  32'hF);
    chk("rst_wb_dstM",  32'(wb_dstM),  32'hF);
    chk("rst_wb_stat",  32'(wb_stat),  32'h1);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: OPL
    push_wb(8'h6, 32'h11, 32'h0, 8'h3, 8'hF, 3'd1, 1);
    run_instr(8'h6, 8'h4, 32'h0, 32'h0, 32'h11, 8'h3, -1, 32'h0, 1'b0, 4, st, rc, wc);
    chk("opl_stalls", 32'(st), 32'd0);
    chk("opl_wb_lat", 32'(wc), 32'd1);
    chk("opl_no_req", 32'(rc), 32'hFFFF_FFFF);

    // 2: MRMOVL, ack 3 cycles after req (coincides with counter expiry: ack wins)
    push_req(1'b0, 32'h100, 32'h0);
    push_wb(8'h5, 32'h100, 32'hDEAD_BEEF, 8'hF, 8'h2, 3'd1, 1);
    run_instr(8'h5, 8'h2, 32'h55, 32'h0, 32'h100, 8'hF, 3, 32'hDEAD_BEEF, 1'b0, 8, st, rc, wc);
    chk("mrmovl_stalls", 32'(st), 32'd4);
    chk("mrmovl_req_c",  32'(rc), 32'd1);
    chk("mrmovl_wb_c",   32'(wc), 32'd5);

    // 3: CALL, immediate ack
    push_req(1'b1, 32'hFC, 32'h40);
    push_wb(8'h8, 32'hFC, 32'h0, 8'h4, 8'hF, 3'd1, 1);
    run_instr(8'h8, 8'hF, 32'h77, 32'h40, 32'hFC, 8'h4, 0, 32'h0, 1'b0, 6, st, rc, wc);
    chk("call_stalls", 32'(st), 32'd1);
    chk("call_wb_c",   32'(wc), 32'd2);

    // POPL: address from valA, loads dstM = rA
    push_req(1'b0, 32'h200, 32'h0);
    push_wb(8'hB, 32'h204, 32'h1234, 8'h4, 8'h6, 3'd1, 1);
    run_instr(8'hB, 8'h6, 32'h200, 32'h0, 32'h204, 8'h4, 1, 32'h1234, 1'b0, 6, st, rc, wc);
    chk("popl_stalls", 32'(st), 32'd2);

    // RMMOVL: write of valA, rdata on ack must not reach valM
    push_req(1'b1, 32'h300, 32'hCAFE);
    push_wb(8'h4, 32'h300, 32'h0, 8'hF, 8'hF, 3'd1, 1);
    run_instr(8'h4, 8'h3, 32'hCAFE, 32'h0, 32'h300, 8'hF, 2, 32'h9999, 1'b0, 6, st, rc, wc);
    chk("rmmovl_stalls", 32'(st), 32'd3);

    // Stray ack in IDLE is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("idle_ack_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_req", 32'(dmem_req), 32'h0);
    @(posedge clk); #1;

    // 4: misaligned PUSHL
    push_wb(8'hA, 32'h0, 32'h0, 8'h0, 8'h0, 3'd3, 0);
    run_instr(8'hA, 8'h3, 32'h5, 32'h0, 32'h102, 8'h4, -1, 32'h0, 1'b0, 5, st, rc, wc);
    chk("pushl_mis_no_req", 32'(rc), 32'hFFFF_FFFF);
    chk("pushl_mis_wb_c",   32'(wc), 32'd1);
    chk_frozen("pushl_mis");
    do_reset();

    // 5: POPL, ack never returns, TIMEOUT=4
    push_req(1'b0, 32'h200, 32'h0);
    push_wb(8'hB, 32'h0, 32'h0, 8'h0, 8'h0, 3'd3, 0);
    run_instr(8'hB, 8'h6, 32'h200, 32'h0, 32'h204, 8'h4, -1, 32'h0, 1'b0, 8, st, rc, wc);
    chk("timeout_req_c", 32'(rc), 32'd1);
    chk("timeout_span",  32'(wc - rc), 32'd4);
    chk_frozen("timeout");
    do_reset();

    // Error response on read
    push_req(1'b0, 32'h100, 32'h0);
    push_wb(8'h5, 32'h0, 32'h0, 8'h0, 8'h0, 3'd3, 0);
    run_instr(8'h5, 8'h2, 32'h0, 32'h0, 32'h100, 8'hF, 1, 32'hBAD, 1'b1, 6, st, rc, wc);
    chk("err_wb_c", 32'(wc), 32'd3);
    chk_frozen("err");
    do_reset();

    // Illegal icode
    push_wb(8'hC, 32'h0, 32'h0, 8'h0, 8'h0, 3'd4, 0);
    run_instr(8'hC, 8'hF, 32'h0, 32'h0, 32'h0, 8'hF, -1, 32'h0, 1'b0, 4, st, rc, wc);
    chk("ins_wb_c", 32'(wc), 32'd1);
    chk_frozen("ins");
    do_reset();

    // 6: reset mid-ACCESS, then ack
    push_req(1'b0, 32'h100, 32'h0);
    drive(8'h5, 8'h2, 32'h0, 32'h0, 32'h100, 8'hF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_req_before", 32'(dmem_req), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_req_async", 32'(dmem_req), 32'h0);
    chk("midrst_wb_icode",  32'(wb_icode), 32'h1);
    chk("midrst_wb_stat",   32'(wb_stat),  32'h1);
    nop();
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ack_ignored_req", 32'(dmem_req), 32'h0);
    chk("midrst_ack_ignored_wb",  32'(wb_icode), 32'h1);
    @(posedge clk); #1;
    dmem_ack = 1'b0;

    // HALT
    push_wb(8'h0, 32'h0, 32'h0, 8'hF, 8'hF, 3'd2, 1);
    run_instr(8'h0, 8'hF, 32'h0, 32'h0, 32'h0, 8'hF, -1, 32'h0, 1'b0, 4, st, rc, wc);
    chk("halt_wb_c", 32'(wc), 32'd1);
    chk_frozen("halt");

    repeat (2) @(posedge clk);
    chk("sb_wb_drained",  32'(wb_sb.size()),  32'd0);
    chk("sb_req_drained", 32'(req_sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
